// File: rtl/tt_dfd_trace_pkg.sv
// ----------------------------------------------------------------------------
// tt_dfd_trace_pkg
// Shared definitions for the DFD trace packing datapath:
//   - trace_packer_state_e : FSM states of the trace packer
//   - ptr_width / cnt_width : width helpers for fill pointers and entry counts
//   - STAT_W                : width of the optional line statistics counters
// ----------------------------------------------------------------------------
package tt_dfd_trace_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } trace_packer_state_e;

    localparam int STAT_W = 32;

    // A pointer into an n-entry line; a 1-entry line still needs a 1-bit field.
    function automatic int ptr_width(input int n);
        return (n == 1) ? 1 : $clog2(n);
    endfunction

    // A count of 0..n entries inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tt_dfd_generic_rotate.sv
// ----------------------------------------------------------------------------
// tt_dfd_generic_rotate
// Places NUM_IN entries into an NUM_OUT-entry vector offset by ptr_out.
// The input is zero-extended to NUM_OUT entries, then rotated (or shifted,
// when ROTATE=0) left or right by ptr_out.
// Ports:
//   data_in  [NUM_IN][DATA_SIZE]  source entries, slot 0 first
//   ptr_out  [PTR_W]              destination offset (0..NUM_OUT-1)
//   data_out [NUM_OUT][DATA_SIZE] placed entries
// ----------------------------------------------------------------------------
module tt_dfd_generic_rotate #(
    parameter int NUM_IN    = 6,
    parameter int NUM_OUT   = 8,
    parameter bit ROT_LEFT  = 1'b1,
    parameter bit ROTATE    = 1'b1,
    parameter int DATA_SIZE = 10,
    parameter int PTR_W     = 3
) (
    input  logic [NUM_IN-1:0][DATA_SIZE-1:0]  data_in,
    input  logic [PTR_W-1:0]                  ptr_out,
    output logic [NUM_OUT-1:0][DATA_SIZE-1:0] data_out
);

    logic [NUM_OUT-1:0][DATA_SIZE-1:0] ext;

    always_comb begin
        int  src;
        logic wrap;
        ext = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            ext[i] = data_in[i];
        end
        data_out = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (ROT_LEFT) begin
                src  = j - int'(ptr_out);
                wrap = (src < 0);
                if (wrap) src = src + NUM_OUT;
            end else begin
                src  = j + int'(ptr_out);
                wrap = (src >= NUM_OUT);
                if (wrap) src = src - NUM_OUT;
            end
            // In shift mode, entries that would wrap around are dropped.
            if (ROTATE || !wrap) begin
                data_out[j] = ext[src];
            end
        end
    end

endmodule

// File: rtl/tt_dfd_trace_packer.sv
// ----------------------------------------------------------------------------
// tt_dfd_trace_packer
// Packs variable-count trace entry groups (0..NUM_IN per cycle) into
// NUM_OUT-entry lines. Entries are written at a wrapping fill pointer; a
// completed line is loaded into a single registered output slot. A flush
// request emits the current partial line (zero-padded).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid/in_ready    input group handshake; in_count entries in data_in
//   data_in              NUM_IN entries, slot 0 oldest
//   flush                single-cycle request to emit the partial line
//   out_valid/out_ready  output line handshake
//   out_data/out_count   line (slot 0 oldest) and number of valid entries
// Optional (macro TRACE_PACKER_STATS_EN):
//   stat_full_lines, stat_flush_lines  saturating counts of loaded lines
// ----------------------------------------------------------------------------
module tt_dfd_trace_packer
    import tt_dfd_trace_pkg::*;
#(
    parameter int NUM_IN    = 6,
    parameter int NUM_OUT   = 8,
    parameter int DATA_SIZE = 10,
    parameter int PTR_W     = ptr_width(NUM_OUT),
    parameter int CNT_W     = cnt_width(NUM_OUT)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    input  logic [CNT_W-1:0]                  in_count,
    input  logic [NUM_IN-1:0][DATA_SIZE-1:0]  data_in,
    output logic                              in_ready,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_OUT-1:0][DATA_SIZE-1:0] out_data,
    output logic [CNT_W-1:0]                  out_count
`ifdef TRACE_PACKER_STATS_EN
    ,
    output logic [STAT_W-1:0]                 stat_full_lines,
    output logic [STAT_W-1:0]                 stat_flush_lines
`endif
);

    localparam logic [CNT_W:0]   NUM_OUT_S = (CNT_W + 1)'(NUM_OUT);
    localparam logic [CNT_W-1:0] NUM_IN_C  = CNT_W'(NUM_IN);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_OUT);

    trace_packer_state_e               state_q, state_d;
    logic [NUM_OUT-1:0][DATA_SIZE-1:0] acc_q, acc_d;
    logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic                              out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0][DATA_SIZE-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]                  out_count_q, out_count_d;

    logic [NUM_OUT-1:0][DATA_SIZE-1:0] rot;
    logic                              slot_free;
    logic                              flush_pend;
    logic                              accept;
    logic [CNT_W:0]                    sum;
    logic                              load_full;
    logic                              load_flush;

    tt_dfd_generic_rotate #(
        .NUM_IN    (NUM_IN),
        .NUM_OUT   (NUM_OUT),
        .ROT_LEFT  (1'b1),
        .ROTATE    (1'b1),
        .DATA_SIZE (DATA_SIZE),
        .PTR_W     (PTR_W)
    ) u_rotate (
        .data_in   (data_in),
        .ptr_out   (wr_ptr_q),
        .data_out  (rot)
    );

    // The pending flush is exactly the FLUSH state.
    assign flush_pend = (state_q == FLUSH);
    assign slot_free  = !out_valid_q || out_ready;
    assign in_ready   = slot_free && !flush_pend;
    assign accept     = in_valid && in_ready;
    assign sum        = (CNT_W + 1)'(wr_ptr_q) + (CNT_W + 1)'(in_count);
    assign load_full  = accept && (sum >= NUM_OUT_S);
    // Accepts are blocked in FLUSH, so the two load kinds are exclusive.
    assign load_flush = flush_pend && slot_free && (wr_ptr_q != '0);

    always_comb begin
        int off;
        state_d     = state_q;
        acc_d       = acc_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (accept) begin
            // Write the wrapping window wr_ptr .. wr_ptr+c-1 (mod NUM_OUT).
            for (int j = 0; j < NUM_OUT; j++) begin
                off = j - int'(wr_ptr_q);
                if (off < 0) off = off + NUM_OUT;
                if (off < int'(in_count)) acc_d[j] = rot[j];
            end
            wr_ptr_d = load_full ? PTR_W'(sum - NUM_OUT_S) : PTR_W'(sum);
        end

        case (state_q)
            FILL:  if (flush) state_d = FLUSH;
            FLUSH: if (slot_free) begin
                state_d  = FILL;
                wr_ptr_d = '0;
            end
            default: state_d = FILL;
        endcase

        if (load_full) begin
            out_valid_d = 1'b1;
            out_count_d = FULL_CNT;
            for (int j = 0; j < NUM_OUT; j++) begin
                out_data_d[j] = (j < int'(wr_ptr_q)) ? acc_q[j] : rot[j];
            end
        end else if (load_flush) begin
            out_valid_d = 1'b1;
            out_count_d = CNT_W'(wr_ptr_q);
            for (int j = 0; j < NUM_OUT; j++) begin
                out_data_d[j] = (j < int'(wr_ptr_q)) ? acc_q[j] : '0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    // Accumulator contents above wr_ptr are don't-care, so no reset needed.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

`ifdef TRACE_PACKER_STATS_EN
    logic [STAT_W-1:0] stat_full_q, stat_full_d;
    logic [STAT_W-1:0] stat_flush_q, stat_flush_d;

    always_comb begin
        stat_full_d  = stat_full_q;
        stat_flush_d = stat_flush_q;
        if (load_full && (stat_full_q != '1))   stat_full_d  = stat_full_q + 1'b1;
        if (load_flush && (stat_flush_q != '1)) stat_flush_d = stat_flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_full_q  <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_full_q  <= stat_full_d;
            stat_flush_q <= stat_flush_d;
        end
    end

    assign stat_full_lines  = stat_full_q;
    assign stat_flush_lines = stat_flush_q;
`endif

    a_count_legal: assert property (@(posedge clk) disable iff (!reset_n)
        (in_valid && in_ready) |-> (in_count <= NUM_IN_C));

endmodule
